plot_scheduler: RTL
===================

// Module: plot_scheduler
// PURPOSE
//  Shares the single VGA pixel writer between three screen-object requesters: 0=ball, 1=paddle, 2=brick.
//  Each requester posts a rectangle job: old position, new position and size.
//  The block arbitrates round-robin, erases the old rectangle in background colour, then draws the new one.
//  Output is one pixel per clock. Sits between game logic and the VGA adapter, replacing the startPlot/object mux.
// PARAMETERS
//  MAX_X        159     last visible column; pixels with x>MAX_X are suppressed
//  MAX_Y        119     last visible row; pixels with y>MAX_Y are suppressed
//  BG_COLOUR    3'b000  erase colour
//  OBJ_COLOUR   9'b010_111_100  {brick,paddle,ball} draw colours, 3 bits each
//  ERASE_ONLY   3'b100  per-requester mask; 1 = job has no draw phase (brick removal)
// PORTS
//  clk         in   1   system clock
//  resetn      in   1   asynchronous active-low reset
//  req         in   3   job request per requester, level, held until ack
//  ack         out  3   one-cycle pulse: job of that requester finished
//  req_new_x   in   24  {r2,r1,r0} 8-bit new top-left x
//  req_new_y   in   21  {r2,r1,r0} 7-bit new top-left y
//  req_old_x   in   24  {r2,r1,r0} 8-bit old top-left x
//  req_old_y   in   21  {r2,r1,r0} 7-bit old top-left y
//  req_size_x  in   24  {r2,r1,r0} 8-bit width in pixels
//  req_size_y  in   21  {r2,r1,r0} 7-bit height in pixels
//  vga_x       out  8   pixel column to VGA adapter
//  vga_y       out  7   pixel row
//  vga_colour  out  3   pixel colour
//  vga_plot    out  1   write enable, one pixel per asserted cycle
//  busy        out  1   high in every state except IDLE
// BEHAVIOUR
//  Reset (async, resetn=0): state=IDLE, rr pointer=0, ack=0, vga_x=0, vga_y=0, vga_colour=0, vga_plot=0, busy=0.
//   Reset mid-job abandons the job with no ack; requester keeps req and is re-served from scratch.
//  FSM: IDLE -> GRANT -> ERASE -> DRAW -> DONE -> IDLE. All outputs registered.
//  IDLE: at an edge with any req bit set -> GRANT.
//   Winner = first set bit searching from rr pointer upward, wrapping 2->0.
//  GRANT (1 cycle): latch winner id and its six fields. Next-phase choice:
//   - Skip ERASE if size_x==0, size_y==0, or (old_x==new_x && old_y==new_y).
//   - Skip DRAW if ERASE_ONLY[id] or size==0.
//   - Both skipped -> DONE.
//  ERASE: walk old rectangle, 8-bit px counter inner (0..size_x-1), 7-bit py outer (0..size_y-1), raster order.
//   Output x=old_x+px, y=old_y+py, colour=BG_COLOUR. Sums are 9/8 bits wide with no wrap.
//   vga_plot=0 when sum>MAX_X or sum>MAX_Y; the clipped cycle is still consumed.
//  DRAW: same walk on new rectangle, colour=OBJ_COLOUR[3*id+:3]. First draw pixel directly follows last erase pixel, no gap.
//  DONE (1 cycle): ack[id]=1, vga_plot=0, rr pointer=(id+1) mod 3, -> IDLE.
//  Timing: req sampled at edge E0 in IDLE. First pixel on vga_* after E2. Pixel k after E(2+k).
//   ack high after E(2+N), where N = erase+draw pixel count. Next grant earliest at E(3+N).
//  Job fields are latched at GRANT; changes to req_* afterwards are ignored until the next grant.
//  req deasserted before its grant edge: never served. req held after ack: eligible again under round-robin.
//  ack and vga_plot are never high in the same cycle. busy=0 only in IDLE.
// TESTING
//  1) Ball 4x4, old (10,20), new (11,19), req[0] only -> 16 pixels colour 000 at x10..13,y20..23, then 16 colour 100 at x11..14,y19..22. ack[0] after E34.
//  2) req=3'b111 from reset, each dropped on own ack -> acks in order 0,1,2. Then req=3'b011 with pointer at 0 -> ball first; after ball, pointer=1 -> paddle.
//  3) Brick 16x10 at (32,10), req[2] -> 160 pixels colour 000 in raster order, no draw phase, ack[2] after E162.
//  4) Paddle 20x1, old==new (100,117) -> no erase; 20 pixels colour 111 x100..119 y117; ack[1] after E22.
//  5) Ball 4x4 new (158,117) -> draw cycles for x=160,161 have vga_plot=0. Rows 117..119 plotted; row 120 fully suppressed. Total 16 draw cycles.
//  6) resetn low during ERASE pixel 5 -> all outputs 0 immediately, no ack. Held req re-granted after release with a full 32-pixel job.

Source files
------------

// File: rtl/plot_scheduler.sv
// Round-robin arbiter that shares one VGA pixel writer between ball, paddle and brick.
// Each granted job erases the old rectangle in the background colour, then draws the new one.
module plot_scheduler #(
  parameter int         MAX_X      = 159,
  parameter int         MAX_Y      = 119,
  parameter logic [2:0] BG_COLOUR  = 3'b000,
  parameter logic [8:0] OBJ_COLOUR = 9'b010_111_100,
  parameter logic [2:0] ERASE_ONLY = 3'b100
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [2:0]  req,
  output logic [2:0]  ack,
  input  logic [23:0] req_new_x,
  input  logic [20:0] req_new_y,
  input  logic [23:0] req_old_x,
  input  logic [20:0] req_old_y,
  input  logic [23:0] req_size_x,
  input  logic [20:0] req_size_y,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_plot,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, GRANT, ERASE, DRAW, DONE} state_t;

  state_t     state, next_state;
  logic [1:0] id, rr, winner;
  logic [7:0] old_x, new_x, size_x, px;
  logic [6:0] old_y, new_y, size_y, py;
  logic       draw_en;

  logic [7:0] sel_old_x, sel_new_x, sel_size_x, base_x;
  logic [6:0] sel_old_y, sel_new_y, sel_size_y, base_y;
  logic       sel_erase_only, skip_erase, skip_draw;
  logic [2:0] obj_colour;
  logic [8:0] sum_x;
  logic [7:0] sum_y;
  logic       in_view, last_px, last;

  // Round-robin search upward from the pointer, wrapping 2 -> 0.
  always_comb begin
    winner = 2'd0;
    case (rr)
      2'd1:    winner = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd2:    winner = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: winner = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sel_old_x      = req_old_x[7:0];
    sel_new_x      = req_new_x[7:0];
    sel_size_x     = req_size_x[7:0];
    sel_old_y      = req_old_y[6:0];
    sel_new_y      = req_new_y[6:0];
    sel_size_y     = req_size_y[6:0];
    sel_erase_only = ERASE_ONLY[0];
    obj_colour     = OBJ_COLOUR[2:0];
    case (id)
      2'd1: begin
        sel_old_x      = req_old_x[15:8];
        sel_new_x      = req_new_x[15:8];
        sel_size_x     = req_size_x[15:8];
        sel_old_y      = req_old_y[13:7];
        sel_new_y      = req_new_y[13:7];
        sel_size_y     = req_size_y[13:7];
        sel_erase_only = ERASE_ONLY[1];
        obj_colour     = OBJ_COLOUR[5:3];
      end
      2'd2: begin
        sel_old_x      = req_old_x[23:16];
        sel_new_x      = req_new_x[23:16];
        sel_size_x     = req_size_x[23:16];
        sel_old_y      = req_old_y[20:14];
        sel_new_y      = req_new_y[20:14];
        sel_size_y     = req_size_y[20:14];
        sel_erase_only = ERASE_ONLY[2];
        obj_colour     = OBJ_COLOUR[8:6];
      end
      default: ;
    endcase
  end

  assign skip_erase = (sel_size_x == 8'd0) || (sel_size_y == 7'd0) ||
                      ((sel_old_x == sel_new_x) && (sel_old_y == sel_new_y));
  assign skip_draw  = sel_erase_only || (sel_size_x == 8'd0) || (sel_size_y == 7'd0);

  // Sums are one bit wider than the coordinates so off-screen pixels clip instead of wrapping.
  assign base_x  = (state == DRAW) ? new_x : old_x;
  assign base_y  = (state == DRAW) ? new_y : old_y;
  assign sum_x   = {1'b0, base_x} + {1'b0, px};
  assign sum_y   = {1'b0, base_y} + {1'b0, py};
  assign in_view = (sum_x <= 9'(MAX_X)) && (sum_y <= 8'(MAX_Y));
  assign last_px = (px == size_x - 8'd1);
  assign last    = last_px && (py == size_y - 7'd1);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (|req) next_state = GRANT;
      GRANT:   next_state = !skip_erase ? ERASE : (!skip_draw ? DRAW : DONE);
      ERASE:   if (last) next_state = draw_en ? DRAW : DONE;
      DRAW:    if (last) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= next_state;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      id         <= 2'd0;
      rr         <= 2'd0;
      old_x      <= 8'd0;
      new_x      <= 8'd0;
      size_x     <= 8'd0;
      old_y      <= 7'd0;
      new_y      <= 7'd0;
      size_y     <= 7'd0;
      px         <= 8'd0;
      py         <= 7'd0;
      draw_en    <= 1'b0;
      ack        <= 3'd0;
      vga_x      <= 8'd0;
      vga_y      <= 7'd0;
      vga_colour <= 3'd0;
      vga_plot   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      ack      <= 3'd0;
      vga_plot <= 1'b0;
      busy     <= (next_state != IDLE);
      case (state)
        IDLE: if (|req) id <= winner;
        GRANT: begin
          old_x   <= sel_old_x;
          new_x   <= sel_new_x;
          size_x  <= sel_size_x;
          old_y   <= sel_old_y;
          new_y   <= sel_new_y;
          size_y  <= sel_size_y;
          draw_en <= !skip_draw;
          px      <= 8'd0;
          py      <= 7'd0;
        end
        ERASE, DRAW: begin
          vga_x      <= sum_x[7:0];
          vga_y      <= sum_y[6:0];
          vga_colour <= (state == DRAW) ? obj_colour : BG_COLOUR;
          vga_plot   <= in_view;
          if (last) begin
            px <= 8'd0;
            py <= 7'd0;
          end else if (last_px) begin
            px <= 8'd0;
            py <= py + 7'd1;
          end else begin
            px <= px + 8'd1;
          end
        end
        DONE: begin
          ack[id] <= 1'b1;
          rr      <= (id == 2'd2) ? 2'd0 : id + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
